// File: rtl/apple1_kbd_port.sv
// Apple-1 PIA keyboard port: key FIFO between the PS/2 decoder and the CPU reads of 0xD010/0xD011.
// Optional macro KBD_UPCASE_EN folds lower-case ASCII (0x61-0x7A) to upper case on entry.
module apple1_kbd_port #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk7,
    input  logic       rst_n,
    input  logic       cpu_clken,
    input  logic       key_valid,
    input  logic [6:0] key_ascii,
    input  logic       flush,
    input  logic       cs,
    input  logic       address,
    input  logic       we,
    output logic [7:0] dout,
    output logic       key_ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [6:0]    r_mem [FIFO_DEPTH];
    logic          r_overflow;
    logic          w_overflow_nxt;
    logic [7:0]    r_dout;
    logic [7:0]    w_dout_nxt;
    logic          r_key_ready;

    logic          w_empty;
    logic          w_full;
    logic          w_rd;
    logic          w_kbd_rd;
    logic          w_sr_rd;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [6:0]    w_code;

`ifdef KBD_UPCASE_EN
    assign w_code = (key_ascii >= 7'h61 && key_ascii <= 7'h7A) ? 7'(key_ascii - 7'h20) : key_ascii;
`else
    assign w_code = key_ascii;
`endif

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_rd     = cs & cpu_clken & ~we;
    assign w_kbd_rd = w_rd & ~address;
    assign w_sr_rd  = w_rd & address;
    assign w_pop    = w_kbd_rd & ~w_empty;
    // A pop on the same edge frees the slot, so a full buffer can still accept the key.
    assign w_push   = key_valid & (~w_full | w_pop);
    assign w_drop   = key_valid & w_full & ~w_pop;

    // Next-state for pointers, overflow flag and read data.
    always_comb begin
        w_wr_nxt       = r_wr_ptr;
        w_rd_nxt       = r_rd_ptr;
        w_overflow_nxt = r_overflow;
        w_dout_nxt     = r_dout;
        if (flush) begin
            w_wr_nxt       = '0;
            w_rd_nxt       = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_push) begin
                w_wr_nxt = r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                w_rd_nxt = r_rd_ptr + PW'(1);
            end
            if (w_sr_rd) begin
                w_overflow_nxt = 1'b0;
            end
            // A drop after the status sample is a new event and must stay visible.
            if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end
            if (w_kbd_rd) begin
                w_dout_nxt = w_pop ? {1'b1, r_mem[r_rd_ptr[AW-1:0]]} : 8'h00;
            end else if (w_sr_rd) begin
                w_dout_nxt = {~w_empty, r_overflow, 6'b0};
            end
        end
    end

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_dout      <= 8'h00;
            r_key_ready <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_overflow  <= w_overflow_nxt;
            r_dout      <= w_dout_nxt;
            r_key_ready <= (w_wr_nxt != w_rd_nxt);
        end
    end

    // Storage needs no reset: entries are only visible between the reset pointers.
    always_ff @(posedge clk7) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_code;
        end
    end

    assign dout      = r_dout;
    assign key_ready = r_key_ready;

endmodule

// File: tb/tb_apple1_kbd_port.sv
// Self-checking bench for apple1_kbd_port: directed vectors plus a random run against a queue model.
module tb_apple1_kbd_port;

    localparam int unsigned DEPTH = 8;

    logic       clk7;
    logic       rst_n;
    logic       cpu_clken;
    logic       key_valid;
    logic [6:0] key_ascii;
    logic       flush;
    logic       cs;
    logic       address;
    logic       we;
    logic [7:0] dout;
    logic       key_ready;

    int n_tests;
    int n_fail;

    logic [6:0] q[$];
    logic       m_ovf;
    logic [7:0] m_dout;

    apple1_kbd_port #(.FIFO_DEPTH(DEPTH)) dut (
        .clk7      (clk7),
        .rst_n     (rst_n),
        .cpu_clken (cpu_clken),
        .key_valid (key_valid),
        .key_ascii (key_ascii),
        .flush     (flush),
        .cs        (cs),
        .address   (address),
        .we        (we),
        .dout      (dout),
        .key_ready (key_ready)
    );

    initial clk7 = 1'b0;
    always #5 clk7 = ~clk7;

    function automatic logic [6:0] fold(input logic [6:0] c);
`ifdef KBD_UPCASE_EN
        if (c >= 7'h61 && c <= 7'h7A) return 7'(c - 7'h20);
`endif
        return c;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the current input values.
    task automatic model_step();
        logic rd;
        logic popped;
        rd     = cs & cpu_clken & ~we;
        popped = 1'b0;
        if (flush) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (rd && !address) begin
                if (q.size() > 0) begin
                    m_dout = {1'b1, q.pop_front()};
                    popped = 1'b1;
                end else begin
                    m_dout = 8'h00;
                end
            end else if (rd && address) begin
                m_dout = {q.size() != 0, m_ovf, 6'b0};
                m_ovf  = 1'b0;
            end
            if (key_valid) begin
                if (q.size() < DEPTH) q.push_back(fold(key_ascii));
                else m_ovf = 1'b1;
            end
        end
        if (popped) begin end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic idle();
        key_valid = 1'b0; key_ascii = 7'h00; cs = 1'b0; address = 1'b0;
        we = 1'b0; cpu_clken = 1'b1; flush = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic kv, input logic [6:0] code,
                       input logic c, input logic a, input logic w, input logic en,
                       input logic fl);
        key_valid = kv; key_ascii = code; cs = c; address = a;
        we = w; cpu_clken = en; flush = fl;
        model_step();
        @(posedge clk7);
        #1;
        idle();
        chk({tag, "_dout"}, dout, m_dout);
        chk({tag, "_rdy"}, {7'b0, key_ready}, {7'b0, q.size() != 0});
    endtask

    task automatic push(input string tag, input logic [6:0] code);
        cyc(tag, 1'b1, code, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic kbd_rd(input string tag);
        cyc(tag, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic sr_rd(input string tag);
        cyc(tag, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] held;
        n_tests = 0;
        n_fail  = 0;
        idle();
        model_reset();
        rst_n = 1'b0;
        #3;
        chk("reset_dout", dout, 8'h00);
        chk("reset_rdy", {7'b0, key_ready}, 8'h00);
        #9;
        rst_n = 1'b1;

        // Basic push / status / data sequence.
        push("v030_push", 7'h41);
        chk("v030_rdy", {7'b0, key_ready}, 8'h01);
        sr_rd("v030_sr1");   chk("v030_sr1_c", dout, 8'h80);
        kbd_rd("v030_kbd");  chk("v030_kbd_c", dout, 8'hC1);
        sr_rd("v030_sr2");   chk("v030_sr2_c", dout, 8'h00);

        // Overflow on the ninth key, then FIFO order drain.
        for (int i = 0; i < 9; i++) push("v031_push", 7'(7'h30 + i));
        sr_rd("v031_sr");    chk("v031_sr_c", dout, 8'hC0);
        for (int i = 0; i < 8; i++) begin
            kbd_rd("v031_kbd");
            chk("v031_kbd_c", dout, 8'(8'hB0 + i));
        end
        sr_rd("v031_sr2");   chk("v031_sr2_c", dout, 8'h00);
        kbd_rd("empty_kbd"); chk("empty_kbd_c", dout, 8'h00);

        // Full buffer with simultaneous push and pop.
        for (int i = 0; i < 8; i++) push("v032_fill", 7'(7'h40 + i));
        cyc("v032_both", 1'b1, 7'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("v032_head", dout, 8'hC0);
        sr_rd("v032_sr");    chk("v032_sr_c", dout, 8'h80);
        for (int i = 1; i < 8; i++) kbd_rd("v032_kbd");
        chk("v032_7th", dout, 8'hC7);
        kbd_rd("v032_last"); chk("v032_last_c", dout, 8'hDA);
        chk("v032_empty", {7'b0, key_ready}, 8'h00);

        // Empty buffer: read returns 0 while the same-edge key is kept.
        cyc("v021_both", 1'b1, 7'h2B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("v021_dout", dout, 8'h00);
        kbd_rd("v021_kbd");  chk("v021_kbd_c", dout, 8'hAB);

        // Writes and disabled clock-enable are not accesses.
        push("wr_push", 7'h33);
        cyc("wr_ign", 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("wr_ign_c", dout, 8'hAB);
        cyc("clken_ign", 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clken_ign_c", dout, 8'hAB);
        kbd_rd("wr_kbd");    chk("wr_kbd_c", dout, 8'hB3);

        // Upper-case folding option.
        push("v033_push", 7'h61);
        kbd_rd("v033_kbd");
`ifdef KBD_UPCASE_EN
        chk("v033_c", dout, 8'hC1);
`else
        chk("v033_c", dout, 8'hE1);
`endif

        // Flush wins over a same-edge read and leaves dout alone.
        for (int i = 0; i < 3; i++) push("v034_push", 7'(7'h50 + i));
        held = dout;
        cyc("v034_flush", 1'b1, 7'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("v034_rdy", {7'b0, key_ready}, 8'h00);
        chk("v034_hold", dout, held);
        kbd_rd("v034_kbd");  chk("v034_kbd_c", dout, 8'h00);

        // Asynchronous reset mid-clock discards buffered keys.
        for (int i = 0; i < 5; i++) push("v035_push", 7'(7'h60 + i));
        kbd_rd("v035_kbd");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("v035_rdy", {7'b0, key_ready}, 8'h00);
        chk("v035_dout", dout, 8'h00);
        #2;
        rst_n = 1'b1;
        sr_rd("v035_sr");    chk("v035_sr_c", dout, 8'h00);

        // A key on the first edge after release is stored.
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        push("v027_push", 7'h24);
        kbd_rd("v027_kbd");  chk("v027_kbd_c", dout, 8'hA4);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cyc("rnd",
                1'($urandom_range(0, 9) < 5),
                7'($urandom),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
